// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace-tree multiplier.
// The helpers size the CSA reduction tree and build the Baugh-Wooley correction word.
package wallace_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int PIPE_STAGES = 3;
  localparam int MAX_PW      = 128;

  // Rows left after `layer` 3:2 compression layers starting from `width` rows.
  function automatic int csa_rows(input int width, input int layer);
    int n;
    n = width;
    for (int k = 0; k < layer; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int clog3_depth(input int width);
    int n;
    int d;
    n = width;
    d = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      d++;
    end
    return d;
  endfunction

  // Two's-complement correction: 2^W + 2^(2W-1), taken modulo 2^(2W).
  function automatic logic [MAX_PW-1:0] bw_correction(input int width);
    logic [MAX_PW-1:0] c;
    c = '0;
    c[width]       = 1'b1;
    c[2*width-1]   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wallace_mul_pipe_reduce.sv
// Combinational Wallace reduction: WIDTH partial-product rows compressed by layers of
// full-adder 3:2 counters down to one sum and one carry vector, each 2*WIDTH bits.
module wallace_reduce
  import wallace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] rows_i [WIDTH],
  output logic [2*WIDTH-1:0] sum_o,
  output logic [2*WIDTH-1:0] carry_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int DEPTH = clog3_depth(WIDTH);

  for (genvar k = 0; k <= DEPTH; k++) begin : g_lvl
    localparam int N = csa_rows(WIDTH, k);
    logic [PW-1:0] row [N];

    if (k == 0) begin : g_src
      for (genvar r = 0; r < N; r++) begin : g_cp
        assign row[r] = rows_i[r];
      end
    end else begin : g_csa
      localparam int NP   = csa_rows(WIDTH, k - 1);
      localparam int GRPS = NP / 3;
      localparam int PASS = NP % 3;

      for (genvar g = 0; g < GRPS; g++) begin : g_grp
        logic [PW-1:0] x, y, z, s, c;
        assign x    = g_lvl[k-1].row[3*g];
        assign y    = g_lvl[k-1].row[3*g+1];
        assign z    = g_lvl[k-1].row[3*g+2];
        assign c[0] = 1'b0;
        // Carry out of the top column falls off: the product never exceeds 2*WIDTH bits.
        for (genvar j = 0; j < PW; j++) begin : g_fa
          assign s[j] = x[j] ^ y[j] ^ z[j];
          if (j < PW - 1) begin : g_cy
            assign c[j+1] = (x[j] & y[j]) | (x[j] & z[j]) | (y[j] & z[j]);
          end
        end
        assign row[2*g]   = s;
        assign row[2*g+1] = c;
      end

      for (genvar t = 0; t < PASS; t++) begin : g_pass
        assign row[2*GRPS+t] = g_lvl[k-1].row[3*GRPS+t];
      end
    end
  end

  assign sum_o   = g_lvl[DEPTH].row[0];
  assign carry_o = g_lvl[DEPTH].row[1];

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with valid/ready on both sides.
// Define WMUL_SIGNED_EN to add the signed_mode port (Baugh-Wooley two's-complement).
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef WMUL_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

`ifdef WMUL_SIGNED_EN
  localparam logic [MAX_PW-1:0] BW_FULL = bw_correction(WIDTH);
  localparam logic [PW-1:0]     BW_CORR = BW_FULL[PW-1:0];
  logic sm_p1_q;
`endif

  logic             vld_p1_q, vld_p2_q, vld_p3_q;
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic [PW-1:0]    sum_p2_q, carry_p2_q, sum_p2_d, carry_p2_d;
  logic [PW-1:0]    p_p3_q, p_p3_d;
  logic [PW-1:0]    pp_rows [WIDTH];
  logic             adv;

  assign adv       = out_ready | ~vld_p3_q;
  assign in_ready  = adv;
  assign out_valid = vld_p3_q;
  assign p         = p_p3_q;

  // ---- S1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
`ifdef WMUL_SIGNED_EN
      sm_p1_q  <= 1'b0;
`endif
    end else if (adv) begin
      vld_p1_q <= in_valid;
      a_p1_q   <= a;
      b_p1_q   <= b;
`ifdef WMUL_SIGNED_EN
      sm_p1_q  <= signed_mode;
`endif
    end
  end

  // ---- S1 -> S2: partial products and CSA reduction ----
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_rows[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp_rows[i][i+j] = a_p1_q[j] & b_p1_q[i];
`ifdef WMUL_SIGNED_EN
        // Terms pairing exactly one sign bit carry negative weight: invert them.
        if (sm_p1_q && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          pp_rows[i][i+j] = ~(a_p1_q[j] & b_p1_q[i]);
`endif
      end
    end
`ifdef WMUL_SIGNED_EN
    // Correction bits land in columns that rows 0 and WIDTH-1 leave empty.
    if (sm_p1_q) begin
      pp_rows[0][WIDTH]        = BW_CORR[WIDTH];
      pp_rows[WIDTH-1][PW-1]   = BW_CORR[PW-1];
    end
`endif
  end

  wallace_reduce #(
    .WIDTH   (WIDTH)
  ) u_reduce (
    .rows_i  (pp_rows),
    .sum_o   (sum_p2_d),
    .carry_o (carry_p2_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      sum_p2_q   <= '0;
      carry_p2_q <= '0;
    end else if (adv) begin
      vld_p2_q   <= vld_p1_q;
      sum_p2_q   <= sum_p2_d;
      carry_p2_q <= carry_p2_d;
    end
  end

  // ---- S2 -> S3: final carry-propagate add ----
  assign p_p3_d = sum_p2_q + carry_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3_q <= 1'b0;
      p_p3_q   <= '0;
    end else if (adv) begin
      vld_p3_q <= vld_p2_q;
      p_p3_q   <= p_p3_d;
    end
  end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed and table-driven bench for wallace_mul_pipe at WIDTH=32.
module tb_wallace_mul_pipe;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, signed_mode;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] p;

  int             n_pass  = 0;
  int             n_total = 0;
  logic [2*W-1:0] expq [$];
  vec_t           vt [$];

  always #5 clk = ~clk;

  wallace_mul_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
`ifdef WMUL_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sm);
    logic signed [2*W-1:0] sx, sy;
    if (sm) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  // One clock of stimulus; output transfers are scored against the expected queue.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic sm, input logic ordy, input logic [2*W-1:0] ex);
    in_valid    = iv;
    a           = ia;
    b           = ib;
    signed_mode = sm;
    out_ready   = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL spurious_out: got p=%0h with no operation outstanding", p);
      end else begin
        chk("stream_p", p, expq.pop_front());
      end
    end
    if (in_valid && in_ready) expq.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_p", p, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Basic latency: one operand pair, result three cycles after it is presented.
    in_valid = 1'b1; a = 1; b = 1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_c2_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_c3_valid", out_valid, 1);
    chk("lat_c3_p", p, 64'h1);
    @(posedge clk); #1;
    chk("lat_c4_valid", out_valid, 0);

    // Directed unsigned vectors, streamed back to back.
    vt.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sm: 1'b0, exp: 64'hFFFFFFFE00000001});
    vt.push_back('{a: 32'h80000000, b: 32'h00000002, sm: 1'b0, exp: 64'h0000000100000000});
    vt.push_back('{a: 32'h00000000, b: 32'hDEADBEEF, sm: 1'b0, exp: 64'h0});
    vt.push_back('{a: 32'h12345678, b: 32'h00000009, sm: 1'b0, exp: 64'h00000000A3D70A38});
    vt.push_back('{a: 32'h0000FFFF, b: 32'h0000FFFF, sm: 1'b0, exp: 64'h00000000FFFE0001});
    vt.push_back('{a: 32'hDEADBEEF, b: 32'h00000010, sm: 1'b0, exp: 64'h0000000DEADBEEF0});
    vt.push_back('{a: 32'hFFFFFFFF, b: 32'h80000000, sm: 1'b0, exp: 64'h7FFFFFFF80000000});
    vt.push_back('{a: 32'h00000007, b: 32'h00000006, sm: 1'b0, exp: 64'd42});
`ifdef WMUL_SIGNED_EN
    vt.push_back('{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sm: 1'b1, exp: 64'h0000000000000001});
    vt.push_back('{a: 32'h80000000, b: 32'h80000000, sm: 1'b1, exp: 64'h4000000000000000});
    vt.push_back('{a: 32'h80000000, b: 32'h00000001, sm: 1'b1, exp: 64'hFFFFFFFF80000000});
    vt.push_back('{a: 32'hFFFFFFFE, b: 32'h00000003, sm: 1'b1, exp: 64'hFFFFFFFFFFFFFFFA});
    vt.push_back('{a: 32'h80000000, b: 32'h80000000, sm: 1'b0, exp: 64'h4000000000000000});
    vt.push_back('{a: 32'h80000000, b: 32'h00000001, sm: 1'b0, exp: 64'h0000000080000000});
`endif
    foreach (vt[i]) cycle(1'b1, vt[i].a, vt[i].b, vt[i].sm, 1'b1, vt[i].exp);
    drain();

    // Full-rate streaming: one result per cycle, in order.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      cycle(1'b1, ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0));
      chk("stream_in_ready", in_ready, 1);
      if (i >= 2) chk("stream_out_valid", out_valid, 1);
    end
    drain();

    // Backpressure: three in flight, output stalled for five cycles.
    out_ready = 1'b1; in_valid = 1'b1;
    a = 3;           b = 5;  @(posedge clk); #1;
    a = 32'h10000;   b = 16; @(posedge clk); #1;
    a = 32'hFFFFFFFF; b = 2; @(posedge clk); #1;
    a = 9; b = 9; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_p", p, 64'd15);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("drain1_valid", out_valid, 1);
    chk("drain1_p", p, 64'd15);
    @(posedge clk); #1;
    chk("drain2_valid", out_valid, 1);
    chk("drain2_p", p, 64'h100000);
    @(posedge clk); #1;
    chk("drain3_valid", out_valid, 1);
    chk("drain3_p", p, 64'h1FFFFFFFE);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("drain_no_dup", out_valid, 0);
    end

    // Reset with two operations in S1/S2 discards both.
    in_valid = 1'b1; a = 100; b = 200; @(posedge clk); #1;
    a = 300; b = 400; @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_flush_0", out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_flush_valid", out_valid, 0);
    end
    in_valid = 1'b1; a = 7; b = 6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_p", p, 64'd42);
    @(posedge clk); #1;

    // Random valid/ready on both sides, including simultaneous transfers.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'b0;
`ifdef WMUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`endif
      cycle(1'($urandom_range(0, 1)), ra, rb, rs, 1'($urandom_range(0, 1)), model(ra, rb, rs));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
